// File: rtl/mem_dump_engine_pkg.sv
// ---------------------------------------------------------------------------
// mem_dump_engine_pkg
//   Shared definitions for the data-memory dump engine: FSM state encodings,
//   mode constants and a small state-classification helper.
// ---------------------------------------------------------------------------
package mem_dump_engine_pkg;

  // FSM state encodings, kept as plain constants so the encoding matches the
  // legacy implementation bit-for-bit.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_CAPT  = 3'd2;
  localparam state_t ST_OUT   = 3'd3;
  localparam state_t ST_FILL  = 3'd4;
  localparam state_t ST_FIN   = 3'd5;

  // Operation modes as sampled from the mode input at start.
  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // States in which an operation is actively walking the window. FIN is
  // excluded on purpose: busy drops in the same cycle as the done pulse, and
  // abort has nothing left to cancel there.
  function automatic logic is_active_state(input state_t st);
    return (st == ST_ISSUE) || (st == ST_CAPT) ||
           (st == ST_OUT)   || (st == ST_FILL);
  endfunction

endpackage

// File: rtl/mem_dump_engine_addr_cnt.sv
// ---------------------------------------------------------------------------
// mem_dump_addr_cnt
//   Loadable word-address / remaining-count pair used by the dump engine.
//   The address wraps modulo 2**ADDR_W; the count decrements to zero.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous reset, active low
//   i_load   in   load base/count (takes priority over step)
//   i_base   in   first word index
//   i_count  in   number of words in the window
//   i_step   in   advance: cur += 1, rem -= 1
//   o_cur    out  current word index
//   o_last   out  current word is the final one of the window (rem == 1)
// ---------------------------------------------------------------------------
module mem_dump_addr_cnt #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_cur,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_cur;
  logic [CNT_W-1:0]  r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_cur <= i_base;
      r_rem <= i_count;
    end else if (i_step) begin
      // Plain unsigned add gives the two's-complement wrap (127 -> -128).
      r_cur <= r_cur + ADDR_W'(1);
      r_rem <= r_rem - CNT_W'(1);
    end
  end

  assign o_cur  = r_cur;
  assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/mem_dump_engine.sv
// ---------------------------------------------------------------------------
// mem_dump_engine
//   Walks a signed word-address window of a byte-laned data memory.
//   READ mode streams every word with its signed byte address over a
//   valid/ready port (one word per three cycles at best); FILL mode writes a
//   constant to every word of the window (one word per cycle).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   start      in   launch request, honoured only when idle
//   mode       in   0 = READ/stream, 1 = FILL
//   base_addr  in   first word index (two's complement)
//   count      in   number of words (0 = no memory access, immediate done)
//   fill_data  in   FILL write value
//   abort      in   synchronous abort request
//   mem_addr   out  word address to data memory
//   mem_re     out  read strobe; mem_rdata valid the following cycle
//   mem_we     out  write strobe
//   mem_be     out  byte enables (all ones while writing)
//   mem_wdata  out  write data, lane LANES-1 in MSBs
//   mem_rdata  in   read data, lane LANES-1 in MSBs
//   out_valid  out  stream word present
//   out_ready  in   consumer accepts
//   out_addr   out  signed byte address = word index * LANES
//   out_data   out  stream word
//   busy       out  operation in progress (low during the done cycle)
//   done       out  one-cycle pulse at end of operation
//   aborted    out  qualifies done: operation ended by abort
// ---------------------------------------------------------------------------
module mem_dump_engine
  import mem_dump_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 9
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               mode,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic [CNT_W-1:0]                   count,
  input  logic [8*LANES-1:0]                 fill_data,
  input  logic                               abort,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic                               mem_re,
  output logic                               mem_we,
  output logic [LANES-1:0]                   mem_be,
  output logic [8*LANES-1:0]                 mem_wdata,
  input  logic [8*LANES-1:0]                 mem_rdata,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ADDR_W+$clog2(LANES)-1:0]    out_addr,
  output logic [8*LANES-1:0]                 out_data,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted
);

  localparam int unsigned DATA_W = 8 * LANES;
  localparam int unsigned SHIFT  = $clog2(LANES);
  localparam int unsigned BADR_W = ADDR_W + SHIFT;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t              r_state;
  logic [DATA_W-1:0]   r_fill;
  logic                r_aborted;
  logic [DATA_W-1:0]   r_out_data;
  logic [BADR_W-1:0]   r_out_addr;

  // -------------------------------------------------------------------------
  // Wires
  // -------------------------------------------------------------------------
  state_t              w_next;
  logic                w_load;
  logic                w_step;
  logic                w_abort_take;
  logic [ADDR_W-1:0]   w_cur;
  logic                w_last;
  logic [BADR_W-1:0]   w_byte_addr;

  // -------------------------------------------------------------------------
  // Address / remaining-count pair
  // -------------------------------------------------------------------------
  mem_dump_addr_cnt #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_base  (base_addr),
    .i_count (count),
    .i_step  (w_step),
    .o_cur   (w_cur),
    .o_last  (w_last)
  );

  // Appending SHIFT zero bits to the index multiplies by LANES while keeping
  // the sign bit on top, so the result is already the sign-extended byte
  // address in the wider field.
  assign w_byte_addr = {w_cur, {SHIFT{1'b0}}};

  // Abort is only meaningful while an operation is walking the window.
  assign w_abort_take = abort && is_active_state(r_state);

  // -------------------------------------------------------------------------
  // Next-state / counter control
  // -------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          if (count == '0)
            w_next = ST_FIN;
          else if (mode == MODE_FILL)
            w_next = ST_FILL;
          else
            w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_OUT;
      ST_OUT: begin
        // A handshake coinciding with abort still advances the counters.
        if (out_ready) begin
          w_step = 1'b1;
          w_next = w_last ? ST_FIN : ST_ISSUE;
        end
      end
      ST_FILL: begin
        w_step = 1'b1;
        if (w_last)
          w_next = ST_FIN;
      end
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase

    if (w_abort_take)
      w_next = ST_FIN;
  end

  // -------------------------------------------------------------------------
  // State and data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_fill     <= '0;
      r_aborted  <= 1'b0;
      r_out_data <= '0;
      r_out_addr <= '0;
    end else begin
      r_state <= w_next;

      if (w_load) begin
        r_fill    <= fill_data;
        r_aborted <= 1'b0;
      end else if (w_abort_take) begin
        r_aborted <= 1'b1;
      end

      // Read data arrives one cycle after the ISSUE strobe, i.e. in CAPT;
      // the counter still points at the same word then.
      if (r_state == ST_CAPT) begin
        r_out_data <= mem_rdata;
        r_out_addr <= w_byte_addr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_addr  = w_cur;
  assign mem_re    = (r_state == ST_ISSUE);
  assign mem_we    = (r_state == ST_FILL);
  assign mem_be    = mem_we ? '1 : '0;
  assign mem_wdata = mem_we ? r_fill : '0;

  assign out_valid = (r_state == ST_OUT);
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;

  assign busy      = is_active_state(r_state);
  assign done      = (r_state == ST_FIN);
  assign aborted   = (r_state == ST_FIN) && r_aborted;

endmodule
